svm_sequencer: RTL and testbench
================================

# svm_sequencer

Control-side sequencer for the `svm` triangle-carrier PWM generator. It accepts phase-voltage and carrier-period commands from the current/FOC controller over a valid/ready handshake and double-buffers them. New commands are committed to the `svm` inputs only at the carrier trough (`halt`), so one carrier period never mixes old and new values. It also owns the `svm` reset, giving an enable/start sequence and a sticky fault shutdown.

## Interface
- `D_WIDTH`, 16: width of voltage and period words; must match `svm`.
- `PERIOD_MIN`, 16: smallest accepted `cmd_period`; smaller values are rejected.
- `PERIOD_RST`, 1000: reset value of `periodTop`.

Ports:
- `clk`  in  1  system clock; all flops on posedge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  level; 1 requests PWM running.
- `fault_in`  in  1  level; 1 forces shutdown.
- `halt`  in  1  from `svm`; high while carrier counter == 0.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_vA`, `cmd_vB`, `cmd_vC`  in  D_WIDTH  requested phase voltages.
- `cmd_period`  in  D_WIDTH  requested `periodTop`.
- `vA`, `vB`, `vC`  out  D_WIDTH  active voltages to `svm`.
- `periodTop`  out  D_WIDTH  active period to `svm`.
- `svm_rstb`  out  1  reset to `svm`, active-low, registered.
- `pending`  out  1  a command is buffered and awaits a trough.
- `commit`  out  1  one-cycle pulse when active registers update.
- `err_period`  out  1  one-cycle pulse when a command is rejected.
- `fault_flag`  out  1  high while in FAULT.
- `cycle_count`  out  D_WIDTH  number of troughs in RUN; wraps.

## Operation
- States: OFF, START, RUN, FAULT. Reset enters OFF.
- `trough = halt & ~halt_q`, where `halt_q` is `halt` registered on posedge (reset value 1).
- **OFF:**
  - `svm_rstb` = 0.
  - `cmd_ready` = 1.
  - An accepted valid command writes the active registers directly and pulses `commit`.
  - `enable` = 1 and `fault_in` = 0 → START.
- **START:**
  - `svm_rstb` = 1.
  - `cmd_ready = ~pending`.
  - First `trough` → RUN. That trough performs no commit and no count.
- **RUN:**
  - `cmd_ready = ~pending`.
  - An accepted command sets `pending` and loads the 1-deep buffer.
  - On `trough` with `pending` = 1: active ← buffer, `pending` ← 0, `commit` pulse.
  - Every `trough` increments `cycle_count`.
- **FAULT:**
  - `svm_rstb` = 0, `cmd_ready` = 0, `pending` cleared, `fault_flag` = 1.
  - Exit to OFF only when `enable` = 0 and `fault_in` = 0 in the same cycle.
- `fault_in` = 1 in START or RUN → FAULT. This has priority over everything else.
- `fault_in` = 1 in OFF holds OFF and blocks START.
- `enable` = 0 in START or RUN → OFF. `pending` is discarded; active values are kept.
- **Reject rule:** an accepted command with `cmd_period < PERIOD_MIN` completes the handshake and pulses `err_period`. It is not buffered and not written.
- **Priority:** fault > enable drop > commit > accept.
  - The buffer is never loaded and committed in the same cycle.
  - Accepting on a trough cycle defers the commit to the next trough.

## Timing
- **Reset values:**
  - `vA`/`vB`/`vC` = 0 and `periodTop` = `PERIOD_RST`.
  - `svm_rstb` = 0, `cmd_ready` = 1 (combinational from OFF).
  - `pending`, `commit`, `err_period`, `fault_flag` = 0; `cycle_count` = 0.
- `svm` updates its counter on negedge. `halt` is therefore stable at the posedge, and exactly one posedge sees each trough in RUN.
- **Latency:**
  - Accept at edge N in RUN → `pending` = 1 after N.
  - Commit happens at the first later edge with `trough`. New values are valid at `svm` from that edge.
  - Worst case is about 2·`periodTop` clocks.
- `svm_rstb` changes on the posedge of the transition edge, so it lags the state change by 0 cycles (registered with the state).
- `cycle_count` wraps from 2^D_WIDTH−1 to 0.
- Asynchronous `rstb` mid-operation returns all outputs to reset values immediately.

## Structure
- `svm_pkg`:
  - state enum `svm_seq_state_t` (OFF, START, RUN, FAULT)
  - default `D_WIDTH`
  - `PERIOD_RST` default
- Sub-module `svm_cmd_buffer`: the 1-deep pending buffer, the active registers and the validity check. It has load/commit/flush controls driven by the state machine.

## Test plan
- **OFF load:** reset, send `cmd` (v = 0x1000/0x2000/0x3000, period = 200) → `commit` pulse next edge, outputs show those values, `svm_rstb` = 0.
- **Start:** `enable` = 1 → `svm_rstb` = 1. State goes to RUN at the first trough, about 400 clocks later; `cycle_count` = 0 there, then increments each ~400 clocks.
- **Deferred commit:** in RUN, send period = 100 mid-carrier → `cmd_ready` drops, `pending` = 1, `periodTop` stays 200 until the next trough. At the trough `commit` pulses and `periodTop` = 100.
- **Same-cycle accept and trough:** offer a command on the trough cycle → no commit on that trough; commit occurs at the following trough.
- **Reject:** `cmd_period` = 8 with `PERIOD_MIN` = 16 → `err_period` pulse, `pending` stays 0, outputs unchanged.
- **Fault:** `fault_in` = 1 with `pending` = 1 → next edge FAULT, `svm_rstb` = 0, `pending` = 0, `fault_flag` = 1. `enable` = 1 keeps it in FAULT; `enable` = 0 with `fault_in` = 0 → OFF.

Source files
------------

// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types and defaults for the svm sequencer
package svm_pkg;
  localparam int SVM_D_WIDTH    = 16;
  localparam int SVM_PERIOD_MIN = 16;
  localparam int SVM_PERIOD_RST = 1000;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } svm_seq_state_t;

  function automatic logic seq_is_active(input svm_seq_state_t s);
    return (s == ST_START) || (s == ST_RUN);
  endfunction
endpackage

// File: rtl/svm_cmd_buffer.sv
// rtl/svm_cmd_buffer.sv - 1-deep command buffer, active svm registers and period check
module svm_cmd_buffer
  import svm_pkg::*;
#(
  parameter int D_WIDTH    = SVM_D_WIDTH,
  parameter int PERIOD_MIN = SVM_PERIOD_MIN,
  parameter int PERIOD_RST = SVM_PERIOD_RST
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [D_WIDTH-1:0] cmd_va_i,
  input  logic [D_WIDTH-1:0] cmd_vb_i,
  input  logic [D_WIDTH-1:0] cmd_vc_i,
  input  logic [D_WIDTH-1:0] cmd_period_i,
  input  logic               load_i,
  input  logic               write_i,
  input  logic               commit_i,
  input  logic               flush_i,
  output logic               period_ok_o,
  output logic               pending_o,
  output logic [D_WIDTH-1:0] va_o,
  output logic [D_WIDTH-1:0] vb_o,
  output logic [D_WIDTH-1:0] vc_o,
  output logic [D_WIDTH-1:0] period_o
);
  logic [D_WIDTH-1:0] buf_va_q, buf_vb_q, buf_vc_q, buf_period_q;
  logic [D_WIDTH-1:0] act_va_q, act_vb_q, act_vc_q, act_period_q;
  logic               pend_q;

  assign period_ok_o = (cmd_period_i >= D_WIDTH'(PERIOD_MIN));

  // write_i (OFF) and commit_i (RUN) never coincide; flush_i never meets commit_i
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend_q       <= 1'b0;
      buf_va_q     <= '0;
      buf_vb_q     <= '0;
      buf_vc_q     <= '0;
      buf_period_q <= D_WIDTH'(PERIOD_RST);
      act_va_q     <= '0;
      act_vb_q     <= '0;
      act_vc_q     <= '0;
      act_period_q <= D_WIDTH'(PERIOD_RST);
    end else begin
      if (flush_i) begin
        pend_q <= 1'b0;
      end else if (load_i) begin
        pend_q       <= 1'b1;
        buf_va_q     <= cmd_va_i;
        buf_vb_q     <= cmd_vb_i;
        buf_vc_q     <= cmd_vc_i;
        buf_period_q <= cmd_period_i;
      end else if (commit_i) begin
        pend_q <= 1'b0;
      end

      if (write_i) begin
        act_va_q     <= cmd_va_i;
        act_vb_q     <= cmd_vb_i;
        act_vc_q     <= cmd_vc_i;
        act_period_q <= cmd_period_i;
      end else if (commit_i) begin
        act_va_q     <= buf_va_q;
        act_vb_q     <= buf_vb_q;
        act_vc_q     <= buf_vc_q;
        act_period_q <= buf_period_q;
      end
    end
  end

  assign pending_o = pend_q;
  assign va_o      = act_va_q;
  assign vb_o      = act_vb_q;
  assign vc_o      = act_vc_q;
  assign period_o  = act_period_q;
endmodule

// File: rtl/svm_sequencer.sv
// rtl/svm_sequencer.sv - trough-synchronous command sequencer and reset owner for svm
module svm_sequencer
  import svm_pkg::*;
#(
  parameter int D_WIDTH    = SVM_D_WIDTH,
  parameter int PERIOD_MIN = SVM_PERIOD_MIN,
  parameter int PERIOD_RST = SVM_PERIOD_RST
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic               fault_in,
  input  logic               halt,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [D_WIDTH-1:0] cmd_vA,
  input  logic [D_WIDTH-1:0] cmd_vB,
  input  logic [D_WIDTH-1:0] cmd_vC,
  input  logic [D_WIDTH-1:0] cmd_period,
  output logic [D_WIDTH-1:0] vA,
  output logic [D_WIDTH-1:0] vB,
  output logic [D_WIDTH-1:0] vC,
  output logic [D_WIDTH-1:0] periodTop,
  output logic               svm_rstb,
  output logic               pending,
  output logic               commit,
  output logic               err_period,
  output logic               fault_flag,
  output logic [D_WIDTH-1:0] cycle_count
);
  svm_seq_state_t     state_q;
  logic               halt_q, svm_rstb_q, commit_q, err_q, fault_q;
  logic [D_WIDTH-1:0] count_q;

  logic trough, accept, period_ok, active, fault_hit, drop, live;
  logic buf_load, buf_write, buf_commit, buf_flush, reject;

  assign trough    = halt & ~halt_q;
  assign accept    = cmd_valid & cmd_ready;
  assign active    = seq_is_active(state_q);
  assign fault_hit = active & fault_in;
  assign drop      = active & ~fault_in & ~enable;
  // a handshake completing in a fault or enable-drop cycle is discarded
  assign live       = ~fault_hit & ~drop;
  assign buf_write  = accept & period_ok & (state_q == ST_OFF);
  assign buf_load   = accept & period_ok & active & live;
  assign buf_commit = (state_q == ST_RUN) & trough & pending & live;
  assign buf_flush  = fault_hit | drop | (state_q == ST_FAULT);
  assign reject     = accept & ~period_ok & live;

  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      ST_OFF:           cmd_ready = 1'b1;
      ST_START, ST_RUN: cmd_ready = ~pending;
      default:          cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_OFF;
      halt_q     <= 1'b1;
      svm_rstb_q <= 1'b0;
      commit_q   <= 1'b0;
      err_q      <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      halt_q   <= halt;
      commit_q <= buf_write | buf_commit;
      err_q    <= reject;
      if ((state_q == ST_RUN) && trough && live) count_q <= count_q + D_WIDTH'(1);
      case (state_q)
        ST_OFF: begin
          if (enable && !fault_in) begin
            state_q    <= ST_START;
            svm_rstb_q <= 1'b1;
          end
        end
        ST_START, ST_RUN: begin
          if (fault_in) begin
            state_q    <= ST_FAULT;
            svm_rstb_q <= 1'b0;
            fault_q    <= 1'b1;
          end else if (!enable) begin
            state_q    <= ST_OFF;
            svm_rstb_q <= 1'b0;
          end else if ((state_q == ST_START) && trough) begin
            state_q <= ST_RUN;
          end
        end
        ST_FAULT: begin
          if (!enable && !fault_in) begin
            state_q <= ST_OFF;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_OFF;
          svm_rstb_q <= 1'b0;
          fault_q    <= 1'b0;
        end
      endcase
    end
  end

  svm_cmd_buffer #(
    .D_WIDTH   (D_WIDTH),
    .PERIOD_MIN(PERIOD_MIN),
    .PERIOD_RST(PERIOD_RST)
  ) u_cmd_buffer (
    .clk         (clk),
    .rstb        (rstb),
    .cmd_va_i    (cmd_vA),
    .cmd_vb_i    (cmd_vB),
    .cmd_vc_i    (cmd_vC),
    .cmd_period_i(cmd_period),
    .load_i      (buf_load),
    .write_i     (buf_write),
    .commit_i    (buf_commit),
    .flush_i     (buf_flush),
    .period_ok_o (period_ok),
    .pending_o   (pending),
    .va_o        (vA),
    .vb_o        (vB),
    .vc_o        (vC),
    .period_o    (periodTop)
  );

  assign svm_rstb    = svm_rstb_q;
  assign commit      = commit_q;
  assign err_period  = err_q;
  assign fault_flag  = fault_q;
  assign cycle_count = count_q;
endmodule

// File: tb/tb_svm_sequencer.sv
// tb/tb_svm_sequencer.sv - self-checking bench for svm_sequencer
module tb_svm_sequencer;
  localparam int PMIN = 16;

  logic        clk, rstb, enable, fault_in, halt, cmd_valid, cmd_ready;
  logic [15:0] cmd_vA, cmd_vB, cmd_vC, cmd_period;
  logic [15:0] vA, vB, vC, periodTop, cycle_count;
  logic        svm_rstb, pending, commit, err_period, fault_flag;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;
  bit rand_mode = 0;
  int cnt = 0;

  svm_sequencer #(.D_WIDTH(16), .PERIOD_MIN(PMIN), .PERIOD_RST(1000)) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .fault_in(fault_in), .halt(halt),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vA(cmd_vA), .cmd_vB(cmd_vB), .cmd_vC(cmd_vC), .cmd_period(cmd_period),
    .vA(vA), .vB(vB), .vC(vC), .periodTop(periodTop), .svm_rstb(svm_rstb),
    .pending(pending), .commit(commit), .err_period(err_period),
    .fault_flag(fault_flag), .cycle_count(cycle_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // svm carrier stand-in: counter moves on negedge, halt while it is zero
  always @(negedge clk or negedge rstb) begin
    if (!rstb || svm_rstb !== 1'b1) begin
      cnt  = 0;
      halt = 1'b1;
    end else if (rand_mode) begin
      halt = ($urandom_range(0, 3) == 0);
    end else begin
      cnt  = (cnt + 1 >= 2 * int'(periodTop)) ? 0 : cnt + 1;
      halt = (cnt == 0);
    end
  end

  // behavioural reference: modes and rules as plain variables
  localparam int M_OFF = 0, M_START = 1, M_RUN = 2, M_FAULT = 3;
  int          m_state;
  bit          m_halt_prev, m_pending, m_commit, m_err;
  logic [15:0] m_buf[4];
  logic [15:0] m_act[4];
  logic [15:0] m_count;

  function automatic bit exp_ready();
    return (m_state == M_OFF) || ((m_state == M_START || m_state == M_RUN) && !m_pending);
  endfunction

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_state = M_OFF; m_halt_prev = 1; m_pending = 0; m_commit = 0; m_err = 0;
      m_count = 0;
      m_act[0] = 0; m_act[1] = 0; m_act[2] = 0; m_act[3] = 16'd1000;
    end else begin
      bit tr, acc, ok;
      int nxt;
      tr  = halt && !m_halt_prev;
      acc = cmd_valid && exp_ready();
      ok  = (int'(cmd_period) >= PMIN);
      nxt = m_state;
      m_commit = 0;
      m_err = 0;
      if (m_state == M_OFF) begin
        if (acc && ok) begin
          m_act[0] = cmd_vA; m_act[1] = cmd_vB; m_act[2] = cmd_vC; m_act[3] = cmd_period;
          m_commit = 1;
        end else if (acc) m_err = 1;
        if (enable && !fault_in) nxt = M_START;
      end else if (m_state == M_FAULT) begin
        m_pending = 0;
        if (!enable && !fault_in) nxt = M_OFF;
      end else if (fault_in) begin
        m_pending = 0;
        nxt = M_FAULT;
      end else if (!enable) begin
        m_pending = 0;
        nxt = M_OFF;
      end else begin
        if (m_state == M_RUN && tr) begin
          m_count = m_count + 16'd1;
          if (m_pending) begin
            m_act = m_buf;
            m_pending = 0;
            m_commit = 1;
          end
        end
        if (acc && ok) begin
          m_buf[0] = cmd_vA; m_buf[1] = cmd_vB; m_buf[2] = cmd_vC; m_buf[3] = cmd_period;
          m_pending = 1;
        end else if (acc) m_err = 1;
        if (m_state == M_START && tr) nxt = M_RUN;
      end
      m_state = nxt;
      m_halt_prev = halt;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("cmd_ready", 32'(cmd_ready), 32'(exp_ready()));
      check("vA", 32'(vA), 32'(m_act[0]));
      check("vB", 32'(vB), 32'(m_act[1]));
      check("vC", 32'(vC), 32'(m_act[2]));
      check("periodTop", 32'(periodTop), 32'(m_act[3]));
      check("svm_rstb", 32'(svm_rstb), 32'(m_state == M_START || m_state == M_RUN));
      check("pending", 32'(pending), 32'(m_pending));
      check("commit", 32'(commit), 32'(m_commit));
      check("err_period", 32'(err_period), 32'(m_err));
      check("fault_flag", 32'(fault_flag), 32'(m_state == M_FAULT));
      check("cycle_count", 32'(cycle_count), 32'(m_count));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [15:0] p);
    @(negedge clk);
    cmd_valid = 1; cmd_vA = a; cmd_vB = b; cmd_vC = c; cmd_period = p;
    @(negedge clk);
    cmd_valid = 0;
    #1;
  endtask

  task automatic wait_commit(input int budget, output int n);
    n = 0;
    while (commit !== 1'b1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    bit found;
    rstb = 1; enable = 0; fault_in = 0; cmd_valid = 0;
    cmd_vA = 0; cmd_vB = 0; cmd_vC = 0; cmd_period = 0;
    #3 rstb = 0;
    #1;
    cmp_en = 1;
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_period", 32'(periodTop), 1000);
    check("rst_svm_rstb", 32'(svm_rstb), 0);
    check("rst_count", 32'(cycle_count), 0);
    repeat (3) @(negedge clk);
    rstb = 1;

    // load while OFF goes straight to the active registers
    send(16'h1000, 16'h2000, 16'h3000, 16'd200);
    check("off_commit", 32'(commit), 1);
    check("off_vA", 32'(vA), 32'h1000);
    check("off_vC", 32'(vC), 32'h3000);
    check("off_period", 32'(periodTop), 200);
    check("off_svm_rstb", 32'(svm_rstb), 0);

    @(negedge clk);
    enable = 1;
    @(negedge clk);
    #1;
    check("start_svm_rstb", 32'(svm_rstb), 1);
    repeat (420) @(negedge clk);

    // deferred commit in RUN
    send(16'h0111, 16'h0222, 16'h0333, 16'd100);
    check("defer_pending", 32'(pending), 1);
    check("defer_ready", 32'(cmd_ready), 0);
    check("defer_hold", 32'(periodTop), 200);
    wait_commit(500, n);
    check("defer_commit_seen", 32'(commit), 1);
    check("defer_period", 32'(periodTop), 100);
    check("defer_count", 32'(cycle_count), 1);

    // offer a command on the trough cycle itself
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      #1;
      if (halt && cnt == 0) found = 1;
    end
    check("trough_found", 32'(found), 1);
    cmd_valid = 1; cmd_vA = 16'h0aaa; cmd_vB = 16'h0bbb; cmd_vC = 16'h0ccc; cmd_period = 16'd300;
    @(negedge clk);
    cmd_valid = 0;
    #1;
    check("same_no_commit", 32'(commit), 0);
    check("same_pending", 32'(pending), 1);
    check("same_count", 32'(cycle_count), 2);
    wait_commit(600, n);
    check("same_commit_seen", 32'(commit), 1);
    check("same_gap", 32'(n >= 150), 1);
    check("same_period", 32'(periodTop), 300);

    // reject a short period
    send(16'h7777, 16'h7777, 16'h7777, 16'd8);
    check("rej_err", 32'(err_period), 1);
    check("rej_pending", 32'(pending), 0);
    check("rej_period", 32'(periodTop), 300);

    // fault with a pending command
    send(16'h0001, 16'h0002, 16'h0003, 16'd150);
    check("flt_pre_pending", 32'(pending), 1);
    fault_in = 1;
    @(negedge clk);
    #1;
    check("flt_flag", 32'(fault_flag), 1);
    check("flt_svm_rstb", 32'(svm_rstb), 0);
    check("flt_pending", 32'(pending), 0);
    check("flt_ready", 32'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    fault_in = 0;
    @(negedge clk);
    #1;
    check("flt_hold", 32'(fault_flag), 1);
    enable = 0;
    @(negedge clk);
    #1;
    check("flt_exit_flag", 32'(fault_flag), 0);
    check("flt_exit_ready", 32'(cmd_ready), 1);
    check("flt_keep_period", 32'(periodTop), 300);

    // randomized traffic against the model
    rand_mode = 1;
    enable = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 249) == 0) enable = ~enable;
      if ($urandom_range(0, 399) == 0) fault_in = 1;
      else if (fault_in && $urandom_range(0, 3) == 0) fault_in = 0;
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_vA     = 16'($urandom);
      cmd_vB     = 16'($urandom);
      cmd_vC     = 16'($urandom);
      cmd_period = 16'($urandom_range(0, 60));
    end
    cmd_valid = 0;

    // asynchronous reset mid-operation
    @(posedge clk);
    #2 rstb = 0;
    #1;
    check("arst_period", 32'(periodTop), 1000);
    check("arst_vA", 32'(vA), 0);
    check("arst_svm_rstb", 32'(svm_rstb), 0);
    check("arst_ready", 32'(cmd_ready), 1);
    check("arst_count", 32'(cycle_count), 0);
    check("arst_fault", 32'(fault_flag), 0);
    @(negedge clk);
    rstb = 1;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
